// File: rtl/wb_regfile_if.sv
// MEM/WB-to-writeback bundle plus decode read ports and core status for wb_regfile.
// slave is the register-file side; master is the pipeline / driver side.
interface wb_regfile_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned CNT_W  = 16
);
  logic              wb_valid;
  logic [DATA_W-1:0] readData;
  logic [DATA_W-1:0] nextPC;
  logic [DATA_W-1:0] aluResult;
  logic [2:0]        regSel;
  logic              regWrite;
  logic              mem_to_reg;
  logic              enJAL;
  logic              halt;
  logic [2:0]        rs_sel;
  logic [2:0]        rt_sel;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic [DATA_W-1:0] wb_data;
  logic              halted;
  logic [CNT_W-1:0]  retired;
  logic              err;

  modport master (
    output wb_valid, readData, nextPC, aluResult, regSel, regWrite, mem_to_reg, enJAL, halt,
    output rs_sel, rt_sel,
    input  rs_data, rt_data, wb_data, halted, retired, err
  );

  modport slave (
    input  wb_valid, readData, nextPC, aluResult, regSel, regWrite, mem_to_reg, enJAL, halt,
    input  rs_sel, rt_sel,
    output rs_data, rt_data, wb_data, halted, retired, err
  );
endinterface

// File: rtl/wb_regfile.sv
// Writeback stage and 8-entry register file with halt, retired counter and sticky error flag.
// Define WB_BYPASS_EN to forward the committing value onto the read ports in the same cycle.
module wb_regfile #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned CNT_W  = 16
) (
  input logic         clk,
  input logic         rst,
  wb_regfile_if.slave bus
);
  logic [DATA_W-1:0] r_regs [8];
  logic              r_halted;
  logic              r_err;
  logic [CNT_W-1:0]  r_retired;

  logic [DATA_W-1:0] w_wb_data;
  logic              w_commit;
  logic              w_write;
  logic [DATA_W-1:0] w_rs_data;
  logic [DATA_W-1:0] w_rt_data;

  // enJAL wins over mem_to_reg even when both are set
  always_comb begin
    if (bus.enJAL) begin
      w_wb_data = bus.nextPC;
    end else if (bus.mem_to_reg) begin
      w_wb_data = bus.readData;
    end else begin
      w_wb_data = bus.aluResult;
    end
  end

  assign w_commit = bus.wb_valid & ~r_halted;
  assign w_write  = w_commit & bus.regWrite;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        r_regs[i] <= '0;
      end
      r_halted  <= 1'b0;
      r_err     <= 1'b0;
      r_retired <= '0;
    end else if (w_commit) begin
      if (bus.regWrite) begin
        r_regs[bus.regSel] <= w_wb_data;
      end
      r_retired <= r_retired + 1'b1;
      if (bus.halt) begin
        r_halted <= 1'b1;
      end
      if (bus.regWrite && bus.enJAL && bus.mem_to_reg) begin
        r_err <= 1'b1;
      end
    end
  end

`ifdef WB_BYPASS_EN
  always_comb begin
    w_rs_data = r_regs[bus.rs_sel];
    w_rt_data = r_regs[bus.rt_sel];
    if (w_write && (bus.rs_sel == bus.regSel)) begin
      w_rs_data = w_wb_data;
    end
    if (w_write && (bus.rt_sel == bus.regSel)) begin
      w_rt_data = w_wb_data;
    end
  end
`else
  // Same-cycle read of the destination sees the old value; decode must stall.
  always_comb begin
    w_rs_data = r_regs[bus.rs_sel];
    w_rt_data = r_regs[bus.rt_sel];
  end
`endif

  assign bus.rs_data = w_rs_data;
  assign bus.rt_data = w_rt_data;
  assign bus.wb_data = w_wb_data;
  assign bus.halted  = r_halted;
  assign bus.retired = r_retired;
  assign bus.err     = r_err;
endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Writeback stage plus architectural register file. Consumes the MEM/WB pipeline register outputs, selects the writeback value and commits it to an 8 x DATA_W register array.
- Supplies two decode-stage read ports.
- Tracks the halt and retired-instruction state for the pipelined core.

Parameters:
DATA_W, 16, width of data, PC and register entries
CNT_W, 16, width of retired-instruction counter

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
wb_valid  input  1  MEM/WB holds a real instruction (0 = bubble)
readData  input  DATA_W  load data from MEM/WB
nextPC  input  DATA_W  PC+2 from MEM/WB, the JAL/JALR link value
aluResult  input  DATA_W  ALU result from MEM/WB
regSel  input  3  destination register index
regWrite  input  1  destination write enable
mem_to_reg  input  1  select readData over aluResult
enJAL  input  1  select nextPC (highest priority)
halt  input  1  instruction in WB is HALT
rs_sel  input  3  read port A index
rt_sel  input  3  read port B index
rs_data  output  DATA_W  read port A data
rt_data  output  DATA_W  read port B data
wb_data  output  DATA_W  selected writeback value, combinational, for forwarding
halted  output  1  core halted, sticky
retired  output  CNT_W  count of committed instructions
err  output  1  sticky: conflicting select (enJAL and mem_to_reg both high on a valid write)

Behaviour:
- Clock and reset: single clock clk. rst is synchronous, active-high.
- Reset values, in the cycle after rst is sampled high: all 8 registers = 0, halted = 0, retired = 0, err = 0. rst has priority over every other event, including a commit in the same cycle.
- wb_data mux: enJAL ? nextPC : (mem_to_reg ? readData : aluResult). Purely combinational, independent of wb_valid.
- Commit condition: commit = wb_valid & ~halted.
  - On commit with regWrite=1: reg[regSel] <= wb_data at the rising edge.
  - Register 0 is an ordinary writable register. There is no hardwired zero.
- Retired counter: increments by 1 on every commit, regardless of regWrite. It wraps modulo 2^CNT_W with no saturation.
- Halt:
  - On commit with halt=1, halted <= 1 at that edge.
  - The halting instruction's own register write, if any, and its count increment still take effect.
  - While halted=1: no register writes, retired frozen, read ports still functional.
  - Only rst clears halted.
- Error flag: err <= 1 on commit with regWrite & enJAL & mem_to_reg. The write still proceeds using nextPC (enJAL priority). err is sticky until rst.
- Read ports: combinational from the array. rs_sel = rt_sel is legal, and both ports return the same value.
- Bubbles: wb_valid=0 means no write, no count, no halt or err update, whatever the other inputs are.
- Latency: writeback value is visible in the array at the edge after commit. Same-cycle visibility depends on the optional feature.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined:
  - If commit & regWrite and rs_sel == regSel, then rs_data = wb_data in that same cycle. rt_data behaves the same way.
  - This write-before-read bypass removes the decode/writeback hazard.
- Not defined:
  - Read ports always return the array contents.
  - A same-cycle read of the register being written returns the old value. The hazard unit must stall one cycle.

Test Plan:
- Reset: write several registers, assert rst one cycle -> next cycle all reads 0, halted=0, retired=0, err=0.
- Mux priority: valid, regWrite, regSel=3, aluResult=0x1234, readData=0xBEEF, nextPC=0x0042.
  - mem_to_reg=0, enJAL=0 -> R3=0x1234.
  - mem_to_reg=1 -> R3=0xBEEF.
  - enJAL=1 and mem_to_reg=1 -> R3=0x0042, err=1, err stays 1 afterwards.
- Bubble and counter: 5 valid commits (2 with regWrite=0) interleaved with 3 bubbles carrying regWrite=1, regSel=5, aluResult=0xFFFF -> retired=5, R5 unchanged.
- Halt: commit with halt=1, regWrite=1, regSel=2, aluResult=0x00AA.
  - Result: R2=0x00AA, halted=1, retired +1.
  - A following valid write to R2 of 0x5555 is ignored, and retired is unchanged.
- Bypass: same-cycle write R6=0x0F0F with rs_sel=rt_sel=6, old R6=0x0001.
  - With WB_BYPASS_EN, rs_data = rt_data = 0x0F0F that cycle.
  - Without it, both read 0x0001 that cycle and 0x0F0F the next cycle.
- Wrap: set CNT_W=4, perform 17 commits -> retired=1.
